gpu_mem_arbiter: RTL and testbench
==================================

GPU_MEM_ARBITER -- requirements
Module: gpu_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8'd255: cycles a pending CLUT fill may wait before it is promoted above texture fill.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_pixWrReq / i_pixWrAdr[19:2] / i_pixWrData[31:0] / i_pixWrBE[3:0]  in  pixel write-back request, one 32-bit word.
REQ-005 o_pixWrAck  out  1  pulse: pixel write finished (i_memWDone seen).
REQ-006 i_bgReq / i_bgAdr[19:2]  in  background fetch request, one word.
REQ-007 o_bgDataValid  out  1 / o_bgData  out  32  background read word.
REQ-008 i_texFillReq / i_texFillAdr[19:5]  in  texture cache line fill, 32 bytes.
REQ-009 i_clutFillReq / i_clutFillAdr[19:5]  in  CLUT cache line fill, 32 bytes.
REQ-010 o_fillData  out  32 / o_fillWordIdx  out  3 / o_texFillWrite  out  1 / o_clutFillWrite  out  1  line-fill write port into the caches.
REQ-011 o_texFillComplete / o_clutFillComplete  out  1  pulses: line fully written (drive updateTexCacheComplete / updateClutCacheComplete).
REQ-012 o_memReq, o_memWrite, o_memBurst8  out  1 / o_memAdr  out  [19:2] / o_memWData  out  32 / o_memBE  out  4  memory command.
REQ-013 i_memAck  in  1 / i_memRValid  in  1 / i_memRData  in  32 / i_memWDone  in  1  memory responses.

Function
REQ-014 Fixed priority: pixel write > BG fetch > texture fill > CLUT fill, except REQ-022.
REQ-015 Arbitration occurs only in IDLE; winner latched (id, address, data, BE) for whole transaction; requests are level and held by the requester until its ack/complete pulse.
REQ-016 States: IDLE, CMD, RDATA, WWAIT, DONE.
REQ-017 IDLE -> CMD next cycle when any request high; o_memReq=1 throughout CMD with stable command; CMD -> RDATA (read) or WWAIT (write) on the cycle i_memAck=1.
REQ-018 Pixel write: o_memWrite=1, o_memBurst8=0, address {i_pixWrAdr}; WWAIT -> DONE on i_memWDone.
REQ-019 BG fetch: single-beat read; first i_memRValid in RDATA gives o_bgDataValid=1, o_bgData=i_memRData the same cycle; -> DONE.
REQ-020 Fills: o_memBurst8=1, address {adr[19:5],3'b000}; 3-bit beat counter starts at 0, each i_memRValid asserts o_texFillWrite or o_clutFillWrite combinationally with o_fillWordIdx=counter, o_fillData=i_memRData; 8th beat (counter=7) -> DONE.
REQ-021 DONE lasts exactly 1 cycle, pulses the matching ack/complete, returns to IDLE; a new grant is possible the cycle after DONE (min 1 idle cycle between transactions).
REQ-022 Starvation counter (8 bits) increments each cycle i_clutFillReq=1 and CLUT not granted, saturates at 255, clears on CLUT grant; when counter >= STARVE_LIMIT CLUT fill ranks above texture fill (never above pixel write or BG).
REQ-023 i_memRValid outside RDATA, i_memWDone outside WWAIT, i_memAck outside CMD are ignored.
REQ-024 Request deasserted after grant: transaction still completes and pulses; pulse is harmless.
REQ-025 Simultaneous requests in IDLE: exactly one grant; losers remain pending, no ack.
REQ-026 Beats never reordered; counter wraps 7->0 only via DONE.

Reset
REQ-027 i_rst=1 at a clock edge -> state IDLE, beat counter 0, starvation counter 0, latched command cleared; mid-transaction reset abandons it with no completion pulse.
REQ-028 During and after reset all outputs 0 (o_memReq, o_memWrite, o_memBurst8, o_memAdr, o_memWData, o_memBE, write strobes, pulses, o_bgData, o_fillData, o_fillWordIdx).

Structure
REQ-029 Shared package holds requester-id encoding (PIX=0, BG=1, TEX=2, CLUT=3), state encoding, beat count 8.
REQ-030 One sub-module natural: gpu_mem_prio_sel (combinational 4-way priority select with starvation override); rest in top.

Verification
REQ-031 All four requests high in IDLE -> pixel write granted, o_memWrite=1, o_pixWrAck after i_memWDone; then BG, TEX, CLUT in order.
REQ-032 Tex fill adr 15'h0123, ack after 3 cycles, 8 RValid beats with gaps -> o_memAdr=18'h0918, idx 0..7 in order, o_texFillComplete once, 1 cycle after last beat.
REQ-033 BG read data 32'hDEADBEEF -> o_bgDataValid=1 with that data, single cycle.
REQ-034 STARVE_LIMIT=4, CLUT and TEX held continuously, TEX re-requests immediately -> CLUT granted no later than the first arbitration after 4 waiting cycles.
REQ-035 i_rst asserted on beat 4 of CLUT fill -> no o_clutFillComplete, all outputs 0 next cycle, next request served normally.
REQ-036 Stray i_memRValid in IDLE -> no fill write, no bgDataValid.

Source files
------------

// File: rtl/gpu_mem_arbiter_pkg.sv
// Shared types for the GPU memory arbiter: requester ids, FSM states and the latched memory command.
package gpu_mem_arbiter_pkg;

    localparam int unsigned ADR_W    = 18;  // word address bits [19:2]
    localparam int unsigned LINE_W   = 15;  // cache line address bits [19:5]
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned BEATS    = 8;   // words per cache line fill
    localparam int unsigned BEAT_W   = 3;
    localparam int unsigned STARVE_W = 8;
    localparam int unsigned REQ_N    = 4;

    typedef enum logic [1:0] {
        REQ_PIX  = 2'd0,
        REQ_BG   = 2'd1,
        REQ_TEX  = 2'd2,
        REQ_CLUT = 2'd3
    } reqId_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_RDATA = 3'd2,
        ST_WWAIT = 3'd3,
        ST_DONE  = 3'd4
    } arbState_t;

    typedef struct packed {
        reqId_t              id;
        logic                write;
        logic                burst8;
        logic [ADR_W-1:0]    adr;
        logic [DATA_W-1:0]   wData;
        logic [BE_W-1:0]     be;
    } memCmd_t;

    // Word address of the first word of a 32-byte line.
    function automatic logic [ADR_W-1:0] lineBase(input logic [LINE_W-1:0] lineAdr);
        return {lineAdr, 3'b000};
    endfunction

endpackage

// File: rtl/gpu_mem_prio_sel.sv
// Combinational 4-way priority select: pixel > BG > texture > CLUT, with CLUT lifted above texture when starved.
module gpu_mem_prio_sel
    import gpu_mem_arbiter_pkg::*;
(
    input  logic [REQ_N-1:0] reqVec,
    input  logic             clutPromote,
    output logic             grantValid_c,
    output reqId_t           grantId_c
);

    always_comb begin
        grantValid_c = |reqVec;
        grantId_c    = REQ_PIX;
        if (reqVec[REQ_PIX]) begin
            grantId_c = REQ_PIX;
        end else if (reqVec[REQ_BG]) begin
            grantId_c = REQ_BG;
        end else if (clutPromote && reqVec[REQ_CLUT]) begin
            grantId_c = REQ_CLUT;
        end else if (reqVec[REQ_TEX]) begin
            grantId_c = REQ_TEX;
        end else if (reqVec[REQ_CLUT]) begin
            grantId_c = REQ_CLUT;
        end
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Single-port memory arbiter for pixel write-back, BG fetch and texture/CLUT line fills.
// One transaction at a time; the winner is latched in IDLE and owns the memory until DONE.
module gpu_mem_arbiter
    import gpu_mem_arbiter_pkg::*;
#(
    parameter logic [STARVE_W-1:0] STARVE_LIMIT = 8'd255
) (
    input  logic              clk,
    input  logic              i_rst,

    input  logic              i_pixWrReq,
    input  logic [19:2]       i_pixWrAdr,
    input  logic [31:0]       i_pixWrData,
    input  logic [3:0]        i_pixWrBE,
    output logic              o_pixWrAck,

    input  logic              i_bgReq,
    input  logic [19:2]       i_bgAdr,
    output logic              o_bgDataValid,
    output logic [31:0]       o_bgData,

    input  logic              i_texFillReq,
    input  logic [19:5]       i_texFillAdr,
    input  logic              i_clutFillReq,
    input  logic [19:5]       i_clutFillAdr,

    output logic [31:0]       o_fillData,
    output logic [2:0]        o_fillWordIdx,
    output logic              o_texFillWrite,
    output logic              o_clutFillWrite,
    output logic              o_texFillComplete,
    output logic              o_clutFillComplete,

    output logic              o_memReq,
    output logic              o_memWrite,
    output logic              o_memBurst8,
    output logic [19:2]       o_memAdr,
    output logic [31:0]       o_memWData,
    output logic [3:0]        o_memBE,

    input  logic              i_memAck,
    input  logic              i_memRValid,
    input  logic [31:0]       i_memRData,
    input  logic              i_memWDone
);

    arbState_t             state;
    arbState_t             stateNext;
    memCmd_t               cmd;
    memCmd_t               grantCmd;
    logic [BEAT_W-1:0]     beatCnt;
    logic [STARVE_W-1:0]   starveCnt;
    logic                  memReqQ;
    logic                  pixWrAckQ;
    logic                  texCompQ;
    logic                  clutCompQ;

    logic [REQ_N-1:0]      reqVec;
    logic                  clutPromote;
    logic                  grantValid;
    reqId_t                grantId;
    logic                  grantFire;
    logic                  lastBeat;
    logic                  rBeat;
    logic                  clutOwned;
    logic                  live;

    assign reqVec      = {i_clutFillReq, i_texFillReq, i_bgReq, i_pixWrReq};
    assign clutPromote = (starveCnt >= STARVE_LIMIT);
    assign grantFire   = (state == ST_IDLE) && grantValid;
    assign lastBeat    = !cmd.burst8 || (beatCnt == BEAT_W'(BEATS - 1));
    assign clutOwned   = (state != ST_IDLE) && (cmd.id == REQ_CLUT);
    assign live        = !i_rst;

    gpu_mem_prio_sel u_prioSel (
        .reqVec       (reqVec),
        .clutPromote  (clutPromote),
        .grantValid_c (grantValid),
        .grantId_c    (grantId)
    );

    // Command snapshot for the requester that wins this cycle.
    always_comb begin
        grantCmd    = '0;
        grantCmd.id = grantId;
        case (grantId)
            REQ_PIX: begin
                grantCmd.write = 1'b1;
                grantCmd.adr   = i_pixWrAdr;
                grantCmd.wData = i_pixWrData;
                grantCmd.be    = i_pixWrBE;
            end
            REQ_BG: begin
                grantCmd.adr = i_bgAdr;
                grantCmd.be  = '1;
            end
            REQ_TEX: begin
                grantCmd.burst8 = 1'b1;
                grantCmd.adr    = lineBase(i_texFillAdr);
                grantCmd.be     = '1;
            end
            REQ_CLUT: begin
                grantCmd.burst8 = 1'b1;
                grantCmd.adr    = lineBase(i_clutFillAdr);
                grantCmd.be     = '1;
            end
            default: grantCmd = '0;
        endcase
    end

    // Transaction FSM next state.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (grantValid)  stateNext = ST_CMD;
            ST_CMD:   if (i_memAck)    stateNext = cmd.write ? ST_WWAIT : ST_RDATA;
            ST_RDATA: if (i_memRValid && lastBeat) stateNext = ST_DONE;
            ST_WWAIT: if (i_memWDone)  stateNext = ST_DONE;
            ST_DONE:  stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Latched command and beat counter; the command is dropped once the transaction retires.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            cmd     <= '0;
            beatCnt <= '0;
        end else begin
            if (grantFire) begin
                cmd <= grantCmd;
            end else if (state == ST_DONE) begin
                cmd <= '0;
            end
            if (state == ST_RDATA && i_memRValid && cmd.burst8) begin
                beatCnt <= lastBeat ? '0 : beatCnt + BEAT_W'(1);
            end else if (state == ST_DONE) begin
                beatCnt <= '0;
            end
        end
    end

    // Counts cycles a CLUT fill waits while someone else holds or wins the memory.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            starveCnt <= '0;
        end else if (grantFire && grantId == REQ_CLUT) begin
            starveCnt <= '0;
        end else if (i_clutFillReq && !clutOwned && starveCnt != '1) begin
            starveCnt <= starveCnt + STARVE_W'(1);
        end
    end

    // Registered request strobe and completion pulses (pulses are high exactly during DONE).
    always_ff @(posedge clk) begin
        if (i_rst) begin
            memReqQ   <= 1'b0;
            pixWrAckQ <= 1'b0;
            texCompQ  <= 1'b0;
            clutCompQ <= 1'b0;
        end else begin
            memReqQ   <= (stateNext == ST_CMD);
            pixWrAckQ <= (stateNext == ST_DONE) && (cmd.id == REQ_PIX);
            texCompQ  <= (stateNext == ST_DONE) && (cmd.id == REQ_TEX);
            clutCompQ <= (stateNext == ST_DONE) && (cmd.id == REQ_CLUT);
        end
    end

    // Read beats pass straight through to the requester in the cycle they arrive.
    assign rBeat = live && (state == ST_RDATA) && i_memRValid;

    assign o_bgDataValid      = rBeat && (cmd.id == REQ_BG);
    assign o_bgData           = o_bgDataValid ? i_memRData : '0;
    assign o_texFillWrite     = rBeat && (cmd.id == REQ_TEX);
    assign o_clutFillWrite    = rBeat && (cmd.id == REQ_CLUT);
    assign o_fillData         = (o_texFillWrite || o_clutFillWrite) ? i_memRData : '0;
    assign o_fillWordIdx      = live ? beatCnt : '0;

    assign o_pixWrAck         = live && pixWrAckQ;
    assign o_texFillComplete  = live && texCompQ;
    assign o_clutFillComplete = live && clutCompQ;

    assign o_memReq           = live && memReqQ;
    assign o_memWrite         = live && cmd.write;
    assign o_memBurst8        = live && cmd.burst8;
    assign o_memAdr           = live ? cmd.adr   : '0;
    assign o_memWData         = live ? cmd.wData : '0;
    assign o_memBE            = live ? cmd.be    : '0;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Scoreboard bench for gpu_mem_arbiter: a default instance and a STARVE_LIMIT=4 instance share one memory model.
module tb_gpu_mem_arbiter;
    import gpu_mem_arbiter_pkg::*;

    localparam logic [2:0] EV_PIX = 3'd0, EV_BG = 3'd1, EV_TEXW = 3'd2, EV_CLUTW = 3'd3,
                           EV_TEXDONE = 3'd4, EV_CLUTDONE = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [2:0]  idx;
        logic [31:0] data;
    } ev_t;

    typedef struct packed {
        reqId_t      who;
        logic        write;
        logic        burst8;
        logic [17:0] adr;
        logic [31:0] wData;
        logic [3:0]  be;
    } cmdExp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, sel = 1'b0;
    logic        pixWrReq = 0, bgReq = 0, texReq = 0, clutReq = 0;
    logic [17:0] pixWrAdr = '0, bgAdr = '0;
    logic [31:0] pixWrData = '0;
    logic [3:0]  pixWrBE = '0;
    logic [14:0] texAdr = '0, clutAdr = '0;
    logic        memAck = 0, memRValid = 0, memWDone = 0;
    logic [31:0] memRData = '0;

    // Per-instance outputs (A: default limit, B: limit 4) and the selected view.
    logic        pixWrAckA, bgDataValidA, texFillWriteA, clutFillWriteA, texCompA, clutCompA;
    logic        memReqA, memWriteA, memBurst8A;
    logic [31:0] bgDataA, fillDataA, memWDataA;
    logic [2:0]  fillWordIdxA;
    logic [17:0] memAdrA;
    logic [3:0]  memBEA;
    logic        pixWrAckB, bgDataValidB, texFillWriteB, clutFillWriteB, texCompB, clutCompB;
    logic        memReqB, memWriteB, memBurst8B;
    logic [31:0] bgDataB, fillDataB, memWDataB;
    logic [2:0]  fillWordIdxB;
    logic [17:0] memAdrB;
    logic [3:0]  memBEB;

    wire         pixWrAck     = sel ? pixWrAckB     : pixWrAckA;
    wire         bgDataValid  = sel ? bgDataValidB  : bgDataValidA;
    wire         texFillWrite = sel ? texFillWriteB : texFillWriteA;
    wire         clutFillWrite= sel ? clutFillWriteB: clutFillWriteA;
    wire         texComp      = sel ? texCompB      : texCompA;
    wire         clutComp     = sel ? clutCompB     : clutCompA;
    wire         memReq       = sel ? memReqB       : memReqA;
    wire         memWrite     = sel ? memWriteB     : memWriteA;
    wire         memBurst8    = sel ? memBurst8B    : memBurst8A;
    wire  [31:0] bgData       = sel ? bgDataB       : bgDataA;
    wire  [31:0] fillData     = sel ? fillDataB     : fillDataA;
    wire  [31:0] memWData     = sel ? memWDataB     : memWDataA;
    wire  [2:0]  fillWordIdx  = sel ? fillWordIdxB  : fillWordIdxA;
    wire  [17:0] memAdr       = sel ? memAdrB       : memAdrA;
    wire  [3:0]  memBE        = sel ? memBEB        : memBEA;
    wire         obsOr = pixWrAck | bgDataValid | texFillWrite | clutFillWrite | texComp | clutComp |
                         memReq | memWrite | memBurst8 | (|bgData) | (|fillData) | (|memWData) |
                         (|fillWordIdx) | (|memAdr) | (|memBE);

    gpu_mem_arbiter u_dutA (
        .clk(clk), .i_rst(rst),
        .i_pixWrReq(pixWrReq && !sel), .i_pixWrAdr(pixWrAdr), .i_pixWrData(pixWrData),
        .i_pixWrBE(pixWrBE), .o_pixWrAck(pixWrAckA),
        .i_bgReq(bgReq && !sel), .i_bgAdr(bgAdr), .o_bgDataValid(bgDataValidA), .o_bgData(bgDataA),
        .i_texFillReq(texReq && !sel), .i_texFillAdr(texAdr),
        .i_clutFillReq(clutReq && !sel), .i_clutFillAdr(clutAdr),
        .o_fillData(fillDataA), .o_fillWordIdx(fillWordIdxA), .o_texFillWrite(texFillWriteA),
        .o_clutFillWrite(clutFillWriteA), .o_texFillComplete(texCompA), .o_clutFillComplete(clutCompA),
        .o_memReq(memReqA), .o_memWrite(memWriteA), .o_memBurst8(memBurst8A), .o_memAdr(memAdrA),
        .o_memWData(memWDataA), .o_memBE(memBEA),
        .i_memAck(memAck), .i_memRValid(memRValid), .i_memRData(memRData), .i_memWDone(memWDone)
    );

    gpu_mem_arbiter #(.STARVE_LIMIT(8'd4)) u_dutB (
        .clk(clk), .i_rst(rst),
        .i_pixWrReq(pixWrReq && sel), .i_pixWrAdr(pixWrAdr), .i_pixWrData(pixWrData),
        .i_pixWrBE(pixWrBE), .o_pixWrAck(pixWrAckB),
        .i_bgReq(bgReq && sel), .i_bgAdr(bgAdr), .o_bgDataValid(bgDataValidB), .o_bgData(bgDataB),
        .i_texFillReq(texReq && sel), .i_texFillAdr(texAdr),
        .i_clutFillReq(clutReq && sel), .i_clutFillAdr(clutAdr),
        .o_fillData(fillDataB), .o_fillWordIdx(fillWordIdxB), .o_texFillWrite(texFillWriteB),
        .o_clutFillWrite(clutFillWriteB), .o_texFillComplete(texCompB), .o_clutFillComplete(clutCompB),
        .o_memReq(memReqB), .o_memWrite(memWriteB), .o_memBurst8(memBurst8B), .o_memAdr(memAdrB),
        .o_memWData(memWDataB), .o_memBE(memBEB),
        .i_memAck(memAck), .i_memRValid(memRValid), .i_memRData(memRData), .i_memWDone(memWDone)
    );

    int      nApplied = 0;
    int      nMiss = 0;
    ev_t     expQ[$];
    cmdExp_t cmdQ[$];
    logic    prevTex7 = 1'b0, prevClut7 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [2:0] idx, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.idx = idx; e.data = data;
        expQ.push_back(e);
    endtask

    task automatic popChk(input logic [2:0] kind, input logic [2:0] idx, input logic [31:0] data);
        ev_t e;
        if (expQ.size() == 0) begin
            nApplied++; nMiss++;
            $display("FAIL unexpected output: event kind %0d idx %0d data 0x%0h, want none (t=%0t)",
                     kind, idx, data, $time);
            return;
        end
        e = expQ.pop_front();
        chk("event kind", 64'(kind), 64'(e.kind));
        chk("event word index", 64'(idx), 64'(e.idx));
        chk("event data", 64'(data), 64'(e.data));
    endtask

    // Monitor: every response strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (pixWrAck)      popChk(EV_PIX, 3'd0, 32'd0);
        if (bgDataValid)   popChk(EV_BG, 3'd0, bgData);
        if (texFillWrite)  popChk(EV_TEXW, fillWordIdx, fillData);
        if (clutFillWrite) popChk(EV_CLUTW, fillWordIdx, fillData);
        if (texComp) begin
            popChk(EV_TEXDONE, 3'd0, 32'd0);
            chk("tex complete one cycle after beat 7", 64'(prevTex7), 64'd1);
        end
        if (clutComp) begin
            popChk(EV_CLUTDONE, 3'd0, 32'd0);
            chk("clut complete one cycle after beat 7", 64'(prevClut7), 64'd1);
        end
        prevTex7  = texFillWrite && fillWordIdx == 3'd7;
        prevClut7 = clutFillWrite && fillWordIdx == 3'd7;
    end

    function automatic logic [31:0] memWord(input logic [17:0] adr, input int beat);
        return 32'hDEADBEEF ^ {11'd0, adr, 3'(beat)};
    endfunction

    function automatic cmdExp_t mk(input reqId_t who, input logic w, input logic b8,
                                   input logic [17:0] adr, input logic [31:0] wd, input logic [3:0] be);
        cmdExp_t c;
        c.who = who; c.write = w; c.burst8 = b8; c.adr = adr; c.wData = wd; c.be = be;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dropReq(input reqId_t who);
        case (who)
            REQ_PIX:  pixWrReq = 1'b0;
            REQ_BG:   bgReq    = 1'b0;
            REQ_TEX:  texReq   = 1'b0;
            default:  clutReq  = 1'b0;
        endcase
    endtask

    // Memory model: waits for a request, checks the command, acks, returns data / write-done.
    // dropMode: 0 keep request, 1 drop in DONE, 2 drop right after grant.
    task automatic serve(input int ackDly, input int gap, input int rstBeat, input int dropMode);
        cmdExp_t e;
        bit      got;
        int      nb;
        logic [2:0] wk;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = memReq;
        end
        chk("memReq raised within budget", 64'(got), 64'd1);
        if (!got) return;
        if (cmdQ.size() == 0) begin
            chk("grant expected", 64'd0, 64'd1);
            return;
        end
        e = cmdQ.pop_front();
        chk("cmd write", 64'(memWrite), 64'(e.write));
        chk("cmd burst8", 64'(memBurst8), 64'(e.burst8));
        chk("cmd address", 64'(memAdr), 64'(e.adr));
        if (e.write) begin
            chk("cmd wdata", 64'(memWData), 64'(e.wData));
            chk("cmd byte enables", 64'(memBE), 64'(e.be));
        end
        if (dropMode == 2) dropReq(e.who);
        repeat (ackDly) tick();
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        if (e.write) begin
            repeat (gap) tick();
            memWDone = 1'b1;
            push(EV_PIX, 3'd0, 32'd0);
            tick();
            memWDone = 1'b0;
        end else begin
            nb = e.burst8 ? 8 : 1;
            wk = (e.who == REQ_BG) ? EV_BG : (e.who == REQ_TEX) ? EV_TEXW : EV_CLUTW;
            for (int b = 0; b < nb; b++) begin
                repeat (gap) tick();
                memRValid = 1'b1;
                memRData  = memWord(e.adr, b);
                if (b == rstBeat) begin
                    rst = 1'b1;
                    tick();
                    memRValid = 1'b0;
                    memRData  = '0;
                    @(negedge clk);
                    chk("all outputs zero after mid-fill reset", 64'(obsOr), 64'd0);
                    dropReq(e.who);
                    tick();
                    rst = 1'b0;
                    return;
                end
                push(wk, 3'(b), memRData);
                tick();
                memRValid = 1'b0;
                memRData  = '0;
            end
            if (e.who == REQ_TEX)  push(EV_TEXDONE, 3'd0, 32'd0);
            if (e.who == REQ_CLUT) push(EV_CLUTDONE, 3'd0, 32'd0);
        end
        if (dropMode == 1) dropReq(e.who);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: outputs held at zero even with a request pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("outputs zero in reset", 64'(obsOr), 64'd0);
        pixWrReq = 1'b1;
        repeat (2) @(negedge clk);
        chk("outputs zero in reset with request", 64'(obsOr), 64'd0);
        pixWrReq = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle outputs after reset", 64'(obsOr), 64'd0);

        // Stray responses while idle are ignored.
        tick();
        memRValid = 1'b1; memRData = 32'h5A5A5A5A; memWDone = 1'b1; memAck = 1'b1;
        @(negedge clk);
        chk("stray rvalid: no write/bg strobe", 64'({texFillWrite, clutFillWrite, bgDataValid}), 64'd0);
        tick();
        memRValid = 1'b0; memRData = '0; memWDone = 1'b0; memAck = 1'b0;
        @(negedge clk);
        chk("stray responses: still idle", 64'(memReq), 64'd0);

        // All four requesters at once: PIX, then BG, TEX, CLUT.
        tick();
        pixWrAdr = 18'h12345; pixWrData = 32'hCAFEF00D; pixWrBE = 4'b0110;
        bgAdr = 18'h00000; texAdr = 15'h0123; clutAdr = 15'h7ABC;
        cmdQ.push_back(mk(REQ_PIX,  1'b1, 1'b0, 18'h12345, 32'hCAFEF00D, 4'b0110));
        cmdQ.push_back(mk(REQ_BG,   1'b0, 1'b0, 18'h00000, 32'h0, 4'hF));
        cmdQ.push_back(mk(REQ_TEX,  1'b0, 1'b1, 18'h00918, 32'h0, 4'hF));
        cmdQ.push_back(mk(REQ_CLUT, 1'b0, 1'b1, 18'h3D5E0, 32'h0, 4'hF));
        pixWrReq = 1'b1; bgReq = 1'b1; texReq = 1'b1; clutReq = 1'b1;
        serve(1, 2, -1, 1);
        serve(0, 0, -1, 2);
        serve(3, 1, -1, 1);
        serve(0, 0, -1, 1);

        // Pixel write at the top word address, zero-latency memory.
        tick();
        pixWrAdr = 18'h3FFFF; pixWrData = 32'hFFFFFFFF; pixWrBE = 4'hF;
        cmdQ.push_back(mk(REQ_PIX, 1'b1, 1'b0, 18'h3FFFF, 32'hFFFFFFFF, 4'hF));
        pixWrReq = 1'b1;
        serve(0, 0, -1, 1);

        // Reset on beat 4 of a CLUT fill, then a normal texture fill.
        tick();
        clutAdr = 15'h0001;
        cmdQ.push_back(mk(REQ_CLUT, 1'b0, 1'b1, 18'h00008, 32'h0, 4'hF));
        clutReq = 1'b1;
        serve(2, 1, 4, 0);
        texAdr = 15'h2AAA;
        cmdQ.push_back(mk(REQ_TEX, 1'b0, 1'b1, 18'h15550, 32'h0, 4'hF));
        texReq = 1'b1;
        serve(0, 2, -1, 1);

        // Starvation on the STARVE_LIMIT=4 instance: TEX held continuously, CLUT still wins next.
        repeat (3) tick();
        sel = 1'b1;
        tick();
        texAdr = 15'h0040; clutAdr = 15'h0050;
        cmdQ.push_back(mk(REQ_TEX,  1'b0, 1'b1, 18'h00200, 32'h0, 4'hF));
        cmdQ.push_back(mk(REQ_CLUT, 1'b0, 1'b1, 18'h00280, 32'h0, 4'hF));
        cmdQ.push_back(mk(REQ_TEX,  1'b0, 1'b1, 18'h00200, 32'h0, 4'hF));
        texReq = 1'b1; clutReq = 1'b1;
        serve(1, 0, -1, 0);
        serve(0, 0, -1, 1);
        serve(0, 0, -1, 1);

        repeat (5) tick();
        chk("all expected responses seen", 64'(expQ.size()), 64'd0);
        chk("all expected grants seen", 64'(cmdQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
